// File: rtl/sobel_window_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_window_scan_ctrl
//  Purpose  : Walks every interior 3x3 window of an X_SIZE x Y_SIZE image.
//             For each centre it fetches the nine taps one at a time from a
//             single-outstanding-read memory port, then presents the
//             assembled window to a valid/ready consumer.
//  Ports    : clk_i, rstn_i           - clock, async active-low reset
//             Start_i                 - begin one full-image scan (IDLE only)
//             X_o, Y_o, MemRd_o       - read request and tap coordinates
//             MemWaitReq_i            - read not accepted this cycle
//             MemRdValid_i, MemRdData_i - read return
//             Win_o, WinX_o, WinY_o   - window taps and centre coordinates
//             Valid_o, Ready_i        - window handshake
//             Busy_o, Done_o          - scan status / end-of-scan pulse
//  Revision : 1.0  initial release
// ============================================================================
module sobel_window_scan_ctrl #(
  parameter  int X_SIZE = 100,
  parameter  int Y_SIZE = 100,
  parameter  int DATA_W = 8,
  localparam int X_BITS = $clog2(X_SIZE),
  localparam int Y_BITS = $clog2(Y_SIZE)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  Start_i,
  output logic [X_BITS-1:0]     X_o,
  output logic [Y_BITS-1:0]     Y_o,
  output logic                  MemRd_o,
  input  logic                  MemWaitReq_i,
  input  logic                  MemRdValid_i,
  input  logic [DATA_W-1:0]     MemRdData_i,
  output logic [9*DATA_W-1:0]   Win_o,
  output logic [X_BITS-1:0]     WinX_o,
  output logic [Y_BITS-1:0]     WinY_o,
  output logic                  Valid_o,
  input  logic                  Ready_i,
  output logic                  Busy_o,
  output logic                  Done_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [X_BITS-1:0]   px_q, px_d, x_q, x_d, win_x_q, win_x_d;
  logic [Y_BITS-1:0]   py_q, py_d, y_q, y_d, win_y_q, win_y_d;
  logic [3:0]          k_q, k_d;
  logic [DATA_W-1:0]   tap_q [9];
  logic [DATA_W-1:0]   tap_d [9];
  logic [9*DATA_W-1:0] win_q, win_d;
  logic                mem_rd_q, mem_rd_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [1:0]          tap_row, tap_col;
  logic                last_centre;

  always_comb begin
    state_d  = state_q;
    px_d     = px_q;
    py_d     = py_q;
    k_d      = k_q;
    tap_d    = tap_q;
    win_d    = win_q;
    win_x_d  = win_x_q;
    win_y_d  = win_y_q;
    x_d      = x_q;
    y_d      = y_q;
    tap_row  = 2'd0;
    tap_col  = 2'd0;

    last_centre = (px_q == X_BITS'(X_SIZE - 2)) && (py_q == Y_BITS'(Y_SIZE - 2));

    case (state_q)
      IDLE: begin
        if (Start_i) begin
          state_d = READ;
          px_d    = X_BITS'(1);
          py_d    = Y_BITS'(1);
          k_d     = 4'd0;
        end
      end
      READ: begin
        if (!MemWaitReq_i) state_d = WAIT;
      end
      WAIT: begin
        if (MemRdValid_i) begin
          tap_d[k_q] = MemRdData_i;
          if (k_q == 4'd8) begin
            state_d = OUT;
            win_x_d = px_q;
            win_y_d = py_q;
            // Snapshot includes the tap captured this cycle.
            for (int i = 0; i < 9; i++) win_d[i*DATA_W +: DATA_W] = tap_d[i];
          end else begin
            state_d = READ;
            k_d     = k_q + 4'd1;
          end
        end
      end
      OUT: begin
        if (Ready_i) begin
          k_d = 4'd0;
          if (last_centre) begin
            state_d = DONE;
          end else begin
            state_d = READ;
            if (py_q == Y_BITS'(Y_SIZE - 2)) begin
              py_d = Y_BITS'(1);
              px_d = px_q + X_BITS'(1);
            end else begin
              py_d = py_q + Y_BITS'(1);
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Tap index -> (row, col) offset within the 3x3 window.
    case (k_d)
      4'd0, 4'd1, 4'd2: tap_row = 2'd0;
      4'd3, 4'd4, 4'd5: tap_row = 2'd1;
      default:          tap_row = 2'd2;
    endcase
    case (k_d)
      4'd0, 4'd3, 4'd6: tap_col = 2'd0;
      4'd1, 4'd4, 4'd7: tap_col = 2'd1;
      default:          tap_col = 2'd2;
    endcase

    // Address only moves when a new read is being launched, so it stays
    // frozen through wait-request stalls and between reads.
    if (state_d == READ) begin
      x_d = px_d + X_BITS'(tap_row) - X_BITS'(1);
      y_d = py_d + Y_BITS'(tap_col) - Y_BITS'(1);
    end

    mem_rd_d = (state_d == READ);
    valid_d  = (state_d == OUT);
    busy_d   = (state_d == READ) || (state_d == WAIT) || (state_d == OUT);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      px_q     <= '0;
      py_q     <= '0;
      k_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      win_q    <= '0;
      win_x_q  <= '0;
      win_y_q  <= '0;
      mem_rd_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < 9; i++) tap_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      px_q     <= px_d;
      py_q     <= py_d;
      k_q      <= k_d;
      x_q      <= x_d;
      y_q      <= y_d;
      win_q    <= win_d;
      win_x_q  <= win_x_d;
      win_y_q  <= win_y_d;
      mem_rd_q <= mem_rd_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      for (int i = 0; i < 9; i++) tap_q[i] <= tap_d[i];
    end
  end

  assign X_o     = x_q;
  assign Y_o     = y_q;
  assign MemRd_o = mem_rd_q;
  assign Win_o   = win_q;
  assign WinX_o  = win_x_q;
  assign WinY_o  = win_y_q;
  assign Valid_o = valid_q;
  assign Busy_o  = busy_q;
  assign Done_o  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sobel_window_scan_ctrl
//  Purpose  : Directed self-checking bench for sobel_window_scan_ctrl on a
//             4x4 image whose memory holds mem[x*4+y] = x*4+y.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sobel_window_scan_ctrl;
  localparam int XS = 4;
  localparam int YS = 4;
  localparam int DW = 8;
  localparam int XB = 2;
  localparam int YB = 2;

  logic            clk = 1'b0;
  logic            rstn_i = 1'b0;
  logic            start_i = 1'b0;
  logic            wreq = 1'b0;
  logic            rd_valid = 1'b0;
  logic [DW-1:0]   rd_data = '0;
  logic            ready = 1'b1;
  logic [XB-1:0]   X_o;
  logic [YB-1:0]   Y_o;
  logic            MemRd_o;
  logic [9*DW-1:0] Win_o;
  logic [XB-1:0]   WinX_o;
  logic [YB-1:0]   WinY_o;
  logic            Valid_o, Busy_o, Done_o;

  sobel_window_scan_ctrl #(.X_SIZE(XS), .Y_SIZE(YS), .DATA_W(DW)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .Start_i(start_i),
    .X_o(X_o), .Y_o(Y_o), .MemRd_o(MemRd_o), .MemWaitReq_i(wreq),
    .MemRdValid_i(rd_valid), .MemRdData_i(rd_data),
    .Win_o(Win_o), .WinX_o(WinX_o), .WinY_o(WinY_o),
    .Valid_o(Valid_o), .Ready_i(ready), .Busy_o(Busy_o), .Done_o(Done_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [9*DW-1:0] exp_win(input int px, input int py);
    logic [9*DW-1:0] r;
    int v;
    r = '0;
    for (int k = 0; k < 9; k++) begin
      v = (px + k/3 - 1) * YS + (py + k%3 - 1);
      r[k*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  // Per-test knobs, latched by the responder/monitor when test_id changes.
  int test_id  = 0;
  int wait_arm = 0;
  int hold_arm = 0;
  bit spur_en  = 1'b0;

  // Memory + consumer model: one-cycle read latency, optional wait-request
  // stall on tap (1,1), optional Ready_i hold-off, optional spurious valids.
  initial begin : responder
    int r_id = 0, wait_left = 0, hold_left = 0, ai = 0;
    bit p = 1'b0;
    logic [DW-1:0] a = '0;
    forever begin
      @(negedge clk);
      p  = MemRd_o && !wreq;
      ai = int'(X_o) * YS + int'(Y_o);
      a  = ai[DW-1:0];
      @(posedge clk);
      #1;
      if (test_id != r_id) begin
        r_id = test_id; wait_left = wait_arm; hold_left = hold_arm;
      end
      rd_valid = p || (spur_en && (MemRd_o || Valid_o));
      rd_data  = p ? a : 8'hEE;
      if (MemRd_o && X_o == 2'd1 && Y_o == 2'd1 && wait_left > 0) begin
        wreq = 1'b1; wait_left--;
      end else wreq = 1'b0;
      if (Valid_o && hold_left > 0) begin
        ready = 1'b0; hold_left--;
      end else ready = 1'b1;
    end
  end

  // Monitor: accepted windows, read-request runs, valid runs, done pulses.
  int n_win = 0, n_done = 0, max_rd_run = 0, rd_run = 0, run_x = 0, run_y = 0;
  int max_valid_run = 0, valid_run = 0;
  bit xy_err = 0, win_changed = 0, rd_in_out = 0, done_busy_err = 0;
  logic [9*DW-1:0] mw [8];
  int mx [8];
  int my [8];

  initial begin : monitor
    int m_id = 0;
    bit prev_rd = 0, prev_valid = 0;
    logic [XB-1:0] last_x = '0;
    logic [YB-1:0] last_y = '0;
    logic [9*DW-1:0] win_ref = '0;
    forever begin
      @(negedge clk);
      if (test_id != m_id) begin
        m_id = test_id;
        n_win = 0; n_done = 0; max_rd_run = 0; rd_run = 0; run_x = 0; run_y = 0;
        max_valid_run = 0; valid_run = 0;
        xy_err = 0; win_changed = 0; rd_in_out = 0; done_busy_err = 0;
        for (int i = 0; i < 8; i++) begin mw[i] = '0; mx[i] = 0; my[i] = 0; end
      end
      if (MemRd_o) begin
        if (prev_rd) begin
          rd_run++;
          if (X_o != last_x || Y_o != last_y) xy_err = 1;
        end else rd_run = 1;
        last_x = X_o; last_y = Y_o;
        if (rd_run > max_rd_run) begin
          max_rd_run = rd_run; run_x = int'(X_o); run_y = int'(Y_o);
        end
      end
      prev_rd = MemRd_o;
      if (Valid_o) begin
        if (prev_valid) begin
          valid_run++;
          if (Win_o !== win_ref) win_changed = 1;
        end else begin
          valid_run = 1; win_ref = Win_o;
        end
        if (valid_run > max_valid_run) max_valid_run = valid_run;
        if (MemRd_o) rd_in_out = 1;
        if (ready) begin
          if (n_win < 8) begin
            mw[n_win] = Win_o; mx[n_win] = int'(WinX_o); my[n_win] = int'(WinY_o);
          end
          n_win++;
        end
      end
      prev_valid = Valid_o;
      if (Done_o) begin
        n_done++;
        if (Busy_o) done_busy_err = 1;
      end
    end
  end

  task automatic new_test(input int w, input int h, input bit s);
    @(posedge clk); #3;
    wait_arm = w; hold_arm = h; spur_en = s;
    test_id++;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (Done_o) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    check_eq({tag, "_done_seen"}, ok, 1);
  endtask

  task automatic check_scan(input string pre);
    check_eq({pre, "_nwin"}, n_win, 4);
    check_eq({pre, "_ndone"}, n_done, 1);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s_cx%0d", pre, i), mx[i], (i < 2) ? 1 : 2);
      check_eq($sformatf("%s_cy%0d", pre, i), my[i], (i % 2 == 0) ? 1 : 2);
      check_eq($sformatf("%s_win%0d", pre, i), mw[i], exp_win((i < 2) ? 1 : 2, (i % 2 == 0) ? 1 : 2));
    end
  endtask

  initial begin : main
    int lat;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", {Busy_o, Done_o, Valid_o, MemRd_o, X_o, Y_o, WinX_o, WinY_o, Win_o}, 0);
    @(negedge clk) rstn_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("idle_no_read", {MemRd_o, Busy_o}, 0);

    // Basic scan, latency, done pulse, window retained afterwards
    new_test(0, 0, 0);
    pulse_start();
    check_eq("start_memrd", MemRd_o, 1);
    check_eq("start_busy", Busy_o, 1);
    check_eq("first_tap_xy", {X_o, Y_o}, 0);
    lat = 0;
    while (!Valid_o && lat < 100) begin @(posedge clk); #1; lat++; end
    check_eq("latency", lat, 18);
    wait_done("basic");
    repeat (2) @(posedge clk);
    #1;
    check_scan("basic");
    check_eq("done_not_busy", done_busy_err, 0);
    check_eq("win_retained", Win_o, exp_win(2, 2));
    check_eq("idle_after_done", {Busy_o, MemRd_o, Done_o, Valid_o}, 0);

    // Wait-request stall on tap 4 of the first window
    new_test(3, 0, 0);
    pulse_start();
    wait_done("wait");
    repeat (2) @(posedge clk);
    #1;
    check_eq("wait_rd_run", max_rd_run, 4);
    check_eq("wait_run_x", run_x, 1);
    check_eq("wait_run_y", run_y, 1);
    check_eq("wait_xy_stable", xy_err, 0);
    check_scan("wait");

    // Consumer back-pressure on the first window
    new_test(0, 5, 0);
    pulse_start();
    wait_done("hold");
    repeat (2) @(posedge clk);
    #1;
    check_eq("hold_valid_run", max_valid_run, 6);
    check_eq("hold_win_stable", win_changed, 0);
    check_eq("hold_no_read", rd_in_out, 0);
    check_scan("hold");

    // Spurious valids, Start_i during READ and in the DONE cycle
    new_test(0, 0, 1);
    pulse_start();
    check_eq("spur_in_read", MemRd_o, 1);
    pulse_start();
    wait_done("spur");
    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    check_eq("start_in_done_ignored", {MemRd_o, Busy_o}, 0);
    check_scan("spur");

    // Reset during WAIT of the second window
    new_test(0, 0, 0);
    pulse_start();
    lat = 0;
    while (n_win < 1 && lat < 200) begin @(posedge clk); #1; lat++; end
    check_eq("rst_first_win", n_win, 1);
    lat = 0;
    while (!MemRd_o && lat < 20) begin @(posedge clk); #1; lat++; end
    @(posedge clk);
    #1;
    check_eq("rst_in_wait", {MemRd_o, Valid_o, Busy_o}, 3'b001);
    #2 rstn_i = 1'b0;
    #1;
    check_eq("rst_async_zero", {Busy_o, Done_o, Valid_o, MemRd_o, X_o, Y_o, WinX_o, WinY_o, Win_o}, 0);
    @(posedge clk);
    @(negedge clk) rstn_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_no_read", {MemRd_o, Busy_o}, 0);
    new_test(0, 0, 0);
    pulse_start();
    check_eq("restart_xy", {X_o, Y_o}, 0);
    wait_done("restart");
    repeat (2) @(posedge clk);
    #1;
    check_scan("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
